// File: rtl/sim_mailbox_pkg.sv
// rtl/sim_mailbox_pkg.sv - register offsets and result codes for the simulation mailbox
package sim_mailbox_pkg;

    localparam logic [7:0] REG_STATUS  = 8'h00;
    localparam logic [7:0] REG_CONSOLE = 8'h04;
    localparam logic [7:0] REG_CYCLE   = 8'h08;
    localparam logic [7:0] REG_WDOG    = 8'h0C;
    localparam logic [7:0] REG_LEVEL   = 8'h10;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_PASS    = 2'b01;
    localparam logic [1:0] RES_FAIL    = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

endpackage

// File: rtl/sim_mailbox_fifo.sv
// rtl/sim_mailbox_fifo.sv - console byte FIFO with wrap-bit pointers
module sim_mailbox_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // a simultaneous pop frees the slot the push needs when full
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sim_mailbox_apb.sv
// rtl/sim_mailbox_apb.sv - APB end-of-test mailbox with console FIFO, cycle counter and watchdog
module sim_mailbox_apb
    import sim_mailbox_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 12
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              char_vld,
    output logic [7:0]        char_data,
    input  logic              char_rdy,
    output logic              sim_done,
    output logic [1:0]        sim_result
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-3:0] word_idx;
    logic              unused_addr_bits;
    logic              access, complete, wr_done;
    logic              is_status, is_console, is_cycle, is_wdog, is_level, hit;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [LW-1:0]     fifo_level;
    logic [31:0]       cycle_cnt;
    logic [31:0]       wdog;
    logic              status_set, wdog_load, wdog_expire;

    assign word_idx         = paddr[ADDR_W-1:2];
    assign unused_addr_bits = ^paddr[1:0];

    assign is_status  = (word_idx == (ADDR_W-2)'(REG_STATUS  >> 2));
    assign is_console = (word_idx == (ADDR_W-2)'(REG_CONSOLE >> 2));
    assign is_cycle   = (word_idx == (ADDR_W-2)'(REG_CYCLE   >> 2));
    assign is_wdog    = (word_idx == (ADDR_W-2)'(REG_WDOG    >> 2));
    assign is_level   = (word_idx == (ADDR_W-2)'(REG_LEVEL   >> 2));
    assign hit        = is_status | is_console | is_cycle | is_wdog | is_level;

    // reset aborts any transfer in flight
    assign access   = psel && penable && !preset;
    assign fifo_pop = char_vld && char_rdy;
    assign pready   = access && !(pwrite && is_console && fifo_full && !char_rdy);
    assign pslverr  = access && !hit;
    assign complete = pready;
    assign wr_done  = complete && pwrite;

    assign char_vld = !fifo_empty;

    sim_mailbox_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (pclk),
        .rst       (preset),
        .push      (wr_done && is_console),
        .push_data (pwdata[7:0]),
        .pop       (fifo_pop),
        .head      (char_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        prdata = 32'h0;
        if (access && !pwrite) begin
            if (is_status)     prdata = {29'b0, sim_done, sim_result};
            else if (is_cycle) prdata = cycle_cnt;
            else if (is_wdog)  prdata = wdog;
            else if (is_level) prdata = 32'(fifo_level);
        end
    end

    assign status_set  = wr_done && is_status && (pwdata[1:0] != RES_NONE) && !sim_done;
    assign wdog_load   = wr_done && is_wdog;
    // a software reload on the final tick cancels the timeout
    assign wdog_expire = (wdog == 32'd1) && !sim_done && !wdog_load;

    always_ff @(posedge pclk) begin
        if (preset) begin
            cycle_cnt  <= 32'h0;
            wdog       <= 32'h0;
            sim_done   <= 1'b0;
            sim_result <= RES_NONE;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wdog_load)
                wdog <= pwdata;
            else if (wdog != 32'h0 && !sim_done)
                wdog <= wdog - 32'd1;
            if (status_set) begin
                sim_done   <= 1'b1;
                sim_result <= pwdata[1:0];
            end else if (wdog_expire) begin
                sim_done   <= 1'b1;
                sim_result <= RES_TIMEOUT;
            end
        end
    end

endmodule
